// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: classifies retiring events into records, queues them in a FIFO,
// and holds the halt record aside until the FIFO drains. Optional macro: TRACE_FILTER_NOP_EN.
module retire_trace_buf #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        reg_write,
  input  logic [2:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_kind,
  output logic [15:0] rec_inum,
  output logic [15:0] rec_pc,
  output logic [2:0]  rec_reg,
  output logic [15:0] rec_val,
  output logic [15:0] rec_addr,
  output logic [15:0] rec_mdata,
  output logic        overflow,
  output logic [15:0] drop_cnt,
  output logic        done
);

  // state   | meaning
  // S_RUN   | capturing retire events into the FIFO
  // S_DRAIN | halt seen; no capture, FIFO then halt record drain out
  // S_DONE  | halt record consumed; idle until reset

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [2:0]  wreg;
    logic [15:0] val;
    logic [15:0] addr;
    logic [15:0] mdata;
  } rec_t;

  state_t      state_q, state_d;
  rec_t        mem_q [DEPTH];
  rec_t        mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        halt_held_q, halt_held_d;
  rec_t        halt_rec_q, halt_rec_d;
  logic [15:0] inum_q, inum_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;

  logic [2:0]  kind;
  rec_t        cap_rec, head_rec;
  logic        capture, empty, full, pop, halt_xfer, keep_kind, push_ok, push, drop;
  logic        unused_inst;

  assign unused_inst = ^inst;

  always_comb begin
    kind = 3'd0;
    if (halt)                        kind = 3'd5;
    else if (reg_write && mem_write) kind = 3'd3;
    else if (reg_write && mem_read)  kind = 3'd2;
    else if (reg_write)              kind = 3'd1;
    else if (mem_write)              kind = 3'd4;
  end

  // Fields that do not apply to a kind stay zero.
  always_comb begin
    cap_rec      = '0;
    cap_rec.kind = kind;
    cap_rec.inum = inum_q;
    cap_rec.pc   = pc;
    if (kind == 3'd1 || kind == 3'd2 || kind == 3'd3) begin
      cap_rec.wreg = write_reg;
      cap_rec.val  = write_data;
    end
    if (kind == 3'd2 || kind == 3'd3 || kind == 3'd4) begin
      cap_rec.addr  = mem_addr;
      cap_rec.mdata = mem_data;
    end
  end

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = ((wr_ptr_q - rd_ptr_q) == FULL_CNT);
    head_rec = '0;
    if (!empty)           head_rec = mem_q[rd_ptr_q[AW-1:0]];
    else if (halt_held_q) head_rec = halt_rec_q;

`ifdef TRACE_FILTER_NOP_EN
    keep_kind = (kind != 3'd0);
`else
    keep_kind = 1'b1;
`endif

    capture   = en && (state_q == S_RUN);
    pop       = !empty && rec_ready;
    halt_xfer = empty && halt_held_q && rec_ready;
    push_ok   = capture && !halt && keep_kind;
    push      = push_ok && (!full || pop);
    drop      = push_ok && full && !pop;

    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    halt_held_d = halt_held_q;
    halt_rec_d  = halt_rec_q;
    inum_d      = inum_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    done_d      = done_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = cap_rec;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (capture) inum_d = inum_q + 16'd1;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    // Halt bypasses the FIFO so it can never be lost to a full queue.
    if (capture && halt) begin
      halt_held_d = 1'b1;
      halt_rec_d  = cap_rec;
      state_d     = S_DRAIN;
    end
    if (halt_xfer) begin
      halt_held_d = 1'b0;
      halt_rec_d  = '0;
      state_d     = S_DONE;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      halt_held_q <= 1'b0;
      halt_rec_q  <= '0;
      inum_q      <= '0;
      drop_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      halt_held_q <= halt_held_d;
      halt_rec_q  <= halt_rec_d;
      inum_q      <= inum_d;
      drop_cnt_q  <= drop_cnt_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rec_valid = !empty || halt_held_q;
  assign rec_kind  = head_rec.kind;
  assign rec_inum  = head_rec.inum;
  assign rec_pc    = head_rec.pc;
  assign rec_reg   = head_rec.wreg;
  assign rec_val   = head_rec.val;
  assign rec_addr  = head_rec.addr;
  assign rec_mdata = head_rec.mdata;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed bench for retire_trace_buf: vector table for single-record behaviour,
// hand sequences for overflow, halt drain, mid-drain reset and NOP filtering.
module tb_retire_trace_buf;

  logic        clk = 1'b0;
  logic        rst, en, reg_write, mem_read, mem_write, halt, rec_ready;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data;
  logic [2:0]  write_reg;
  logic        rec_valid, overflow, done;
  logic [2:0]  rec_kind, rec_reg;
  logic [15:0] rec_inum, rec_pc, rec_val, rec_addr, rec_mdata, drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  retire_trace_buf #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
    .halt(halt), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_val(rec_val),
    .rec_addr(rec_addr), .rec_mdata(rec_mdata), .overflow(overflow),
    .drop_cnt(drop_cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, en, rw, mr, mw, hl, rdy;
    logic [2:0]  wreg;
    logic [15:0] wdata, addr, mdata, pc;
    logic        e_valid;
    logic [2:0]  e_kind;
    logic [15:0] e_inum, e_pc;
    logic [2:0]  e_reg;
    logic [15:0] e_val, e_addr, e_mdata;
    logic        e_ovf, e_done;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    reg_write = 0; mem_read = 0; mem_write = 0; halt = 0;
    write_reg = 0; write_data = 0; mem_addr = 0; mem_data = 0; pc = 0;
  endtask

  task automatic do_reset();
    rst = 0; en = 0; rec_ready = 0; clr_ev();
    tick();
    rst = 1;
  endtask

  task automatic alu(input logic [15:0] d);
    clr_ev();
    en = 1; reg_write = 1; write_reg = 3'd3; write_data = d; pc = 16'h0010 + d;
  endtask

  initial begin
    inst = 16'hDEAD;
    rst = 0; en = 0; rec_ready = 0; clr_ev();

    //          rst en rw mr mw hl rdy wreg wdata     addr      mdata     pc         v kind inum pc         reg val       addr      mdata     ovf done
    vecs[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 16'h0,    16'h0,    16'h0,    16'h0,     0, 0, 0, 16'h0,     0, 16'h0,    16'h0,    16'h0,    0, 0};
    vecs[1] = '{1, 1, 1, 0, 0, 0, 1, 2, 16'h0011, 16'h0,    16'h0,    16'h0100,  1, 1, 0, 16'h0100,  2, 16'h0011, 16'h0,    16'h0,    0, 0};
    vecs[2] = '{1, 1, 1, 0, 0, 0, 1, 2, 16'h0022, 16'h0,    16'h0,    16'h0102,  1, 1, 1, 16'h0102,  2, 16'h0022, 16'h0,    16'h0,    0, 0};
    vecs[3] = '{1, 1, 1, 0, 0, 0, 1, 2, 16'h0033, 16'h0,    16'h0,    16'h0104,  1, 1, 2, 16'h0104,  2, 16'h0033, 16'h0,    16'h0,    0, 0};
    vecs[4] = '{1, 0, 0, 0, 0, 0, 1, 0, 16'h0,    16'h0,    16'h0,    16'h0,     0, 0, 0, 16'h0,     0, 16'h0,    16'h0,    16'h0,    0, 0};
    vecs[5] = '{1, 1, 1, 0, 1, 0, 0, 5, 16'h1234, 16'h1000, 16'hBEEF, 16'h0200,  1, 3, 3, 16'h0200,  5, 16'h1234, 16'h1000, 16'hBEEF, 0, 0};
    vecs[6] = '{1, 1, 0, 0, 1, 0, 0, 5, 16'h9999, 16'h2000, 16'h5555, 16'h0202,  1, 3, 3, 16'h0200,  5, 16'h1234, 16'h1000, 16'hBEEF, 0, 0};
    vecs[7] = '{1, 0, 0, 0, 0, 0, 1, 0, 16'h0,    16'h0,    16'h0,    16'h0,     1, 4, 4, 16'h0202,  0, 16'h0,    16'h2000, 16'h5555, 0, 0};
    vecs[8] = '{1, 1, 1, 1, 0, 0, 1, 1, 16'h7777, 16'h3000, 16'h6666, 16'h0204,  1, 2, 5, 16'h0204,  1, 16'h7777, 16'h3000, 16'h6666, 0, 0};
    vecs[9] = '{1, 0, 0, 0, 0, 0, 1, 0, 16'h0,    16'h0,    16'h0,    16'h0,     0, 0, 0, 16'h0,     0, 16'h0,    16'h0,    16'h0,    0, 0};

    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst_n; en = vecs[i].en; reg_write = vecs[i].rw; mem_read = vecs[i].mr;
      mem_write = vecs[i].mw; halt = vecs[i].hl; rec_ready = vecs[i].rdy;
      write_reg = vecs[i].wreg; write_data = vecs[i].wdata; mem_addr = vecs[i].addr;
      mem_data = vecs[i].mdata; pc = vecs[i].pc;
      tick();
      chk($sformatf("vec%0d.valid", i), rec_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d.kind", i),  rec_kind,  vecs[i].e_kind);
      chk($sformatf("vec%0d.inum", i),  rec_inum,  vecs[i].e_inum);
      chk($sformatf("vec%0d.pc", i),    rec_pc,    vecs[i].e_pc);
      chk($sformatf("vec%0d.reg", i),   rec_reg,   vecs[i].e_reg);
      chk($sformatf("vec%0d.val", i),   rec_val,   vecs[i].e_val);
      chk($sformatf("vec%0d.addr", i),  rec_addr,  vecs[i].e_addr);
      chk($sformatf("vec%0d.mdata", i), rec_mdata, vecs[i].e_mdata);
      chk($sformatf("vec%0d.ovf", i),   overflow,  vecs[i].e_ovf);
      chk($sformatf("vec%0d.done", i),  done,      vecs[i].e_done);
      chk($sformatf("vec%0d.drops", i), drop_cnt,  16'd0);
    end

    // Overflow: nine ALU events into an eight-deep FIFO with no consumer.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      alu(16'(i));
      tick();
    end
    en = 0; clr_ev();
    chk("ovf.flag", overflow, 1);
    chk("ovf.drops", drop_cnt, 1);
    chk("ovf.valid", rec_valid, 1);
    rec_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf.inum%0d", i), rec_inum, 16'(i));
      chk($sformatf("ovf.val%0d", i), rec_val, 16'(i));
      tick();
    end
    chk("ovf.empty", rec_valid, 0);
    rec_ready = 0;
    alu(16'h00AA);
    tick();
    en = 0; clr_ev();
    chk("ovf.next_inum", rec_inum, 16'd9);
    chk("ovf.sticky", overflow, 1);

    // Full FIFO with simultaneous pop, then halt while full.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alu(16'(i));
      tick();
    end
    alu(16'd8); rec_ready = 1;
    tick();
    chk("full_pp.ovf", overflow, 0);
    chk("full_pp.drops", drop_cnt, 0);
    chk("full_pp.head", rec_inum, 16'd1);
    rec_ready = 0; clr_ev();
    en = 1; halt = 1; reg_write = 1; mem_write = 1; pc = 16'h0040;
    tick();
    alu(16'h0055);
    tick();
    chk("halt.valid", rec_valid, 1);
    chk("halt.head", rec_inum, 16'd1);
    chk("halt.done0", done, 0);
    rec_ready = 1;
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("halt.fifo_inum%0d", i), rec_inum, 16'(i));
      tick();
    end
    chk("halt.kind", rec_kind, 5);
    chk("halt.inum", rec_inum, 16'd9);
    chk("halt.pc", rec_pc, 16'h0040);
    chk("halt.val", rec_val, 0);
    chk("halt.addr", rec_addr, 0);
    chk("halt.valid2", rec_valid, 1);
    chk("halt.done_pre", done, 0);
    tick();
    chk("halt.done", done, 1);
    chk("halt.valid_off", rec_valid, 0);
    clr_ev(); en = 1; halt = 1; pc = 16'h0099;
    tick();
    tick();
    chk("done.stays", done, 1);
    chk("done.novalid", rec_valid, 0);
    chk("done.kind", rec_kind, 0);

    // Reset while draining with four records still queued.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      alu(16'(i));
      tick();
    end
    en = 0; clr_ev(); rec_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    rec_ready = 0; en = 1; halt = 1; pc = 16'h0080;
    tick();
    clr_ev();
    chk("rstmid.pre_ovf", overflow, 1);
    chk("rstmid.pre_head", rec_inum, 16'd4);
    rst = 0; en = 0;
    tick();
    rst = 1;
    chk("rstmid.valid", rec_valid, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.ovf", overflow, 0);
    chk("rstmid.drops", drop_cnt, 0);
    chk("rstmid.kind", rec_kind, 0);
    alu(16'h0077);
    tick();
    en = 0; clr_ev();
    chk("rstmid.inum", rec_inum, 16'd0);
    chk("rstmid.kind1", rec_kind, 1);
    chk("rstmid.val", rec_val, 16'h0077);

    // NOP, ALU, NOP, ALU.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clr_ev(); en = 1; pc = 16'h0300 + 16'(i);
      if (i % 2 == 1) begin
        reg_write = 1; write_reg = 3'd4; write_data = 16'h00A0 + 16'(i);
      end
      tick();
    end
    en = 0; clr_ev(); rec_ready = 1;
`ifdef TRACE_FILTER_NOP_EN
    for (int i = 1; i < 4; i += 2) begin
      chk($sformatf("filt.inum%0d", i), rec_inum, 16'(i));
      chk($sformatf("filt.kind%0d", i), rec_kind, 1);
      chk($sformatf("filt.val%0d", i), rec_val, 16'h00A0 + 16'(i));
      tick();
    end
`else
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("nop.inum%0d", i), rec_inum, 16'(i));
      chk($sformatf("nop.kind%0d", i), rec_kind, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("nop.val%0d", i), rec_val, (i % 2 == 1) ? 16'h00A0 + 16'(i) : 16'h0);
      chk($sformatf("nop.pc%0d", i), rec_pc, 16'h0300 + 16'(i));
      tick();
    end
`endif
    chk("nop.empty", rec_valid, 0);
    chk("nop.drops", drop_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
